// File: rtl/clz_iter.sv
// clz_iter: iterative leading-zero / leading-one counter.
// Scans CHUNK bits per cycle from the MSB and stops at the first chunk that
// holds a 1. Operands arrive and results leave through valid/ready handshakes.
module clz_iter #(
   parameter  int WIDTH = 32,
   parameter  int CHUNK = 8,
   localparam int NCH   = WIDTH / CHUNK,
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data_in,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW-1:0]    count,
   output logic             all_flag
);

   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CW-1:0]    count_q, count_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             all_q, all_d;
   logic             ov_q, ov_d;
   logic [CHUNK-1:0] top;

   // Leading zeros inside one chunk; only called on a non-zero chunk, so the
   // result stays within 0..CHUNK-1.
   function automatic logic [CW-1:0] lz_chunk(input logic [CHUNK-1:0] v);
      logic [CW-1:0] n;
      logic          found;
      n     = '0;
      found = 1'b0;
      for (int i = CHUNK - 1; i >= 0; i--) begin
         if (!found) begin
            if (v[i]) found = 1'b1;
            else      n = n + CW'(1);
         end
      end
      return n;
   endfunction

   assign top = sreg_q[WIDTH-1 -: CHUNK];

   // Only IDLE accepts, and never while reset is held.
   assign in_ready = (state_q == IDLE) && !rst;

   // Next-state and datapath decode; the scanner only ever looks for a 1
   // because mode inversion happens once at accept.
   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_d = state_q;
      sreg_d  = sreg_q;
      count_d = count_q;
      idx_d   = idx_q;
      all_d   = all_q;
      ov_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               sreg_d  = mode ? ~data_in : data_in;
               count_d = '0;
               idx_d   = '0;
               all_d   = 1'b0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (top != '0) begin
               count_d = count_q + lz_chunk(top);
               ov_d    = 1'b1;
               state_d = DONE;
            end else if (idx_q == LAST_IDX) begin
               count_d = CW'(WIDTH);
               all_d   = 1'b1;
               ov_d    = 1'b1;
               state_d = DONE;
            end else begin
               count_d = count_q + CW'(CHUNK);
               sreg_d  = sreg_q << CHUNK;
               idx_d   = idx_q + IW'(1);
            end
         end
         DONE: begin
            ov_d = 1'b1;
            if (out_ready) begin
               ov_d    = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         count_q <= '0;
         idx_q   <= '0;
         all_q   <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         count_q <= count_d;
         idx_q   <= idx_d;
         all_q   <= all_d;
         ov_q    <= ov_d;
      end
   end

   assign out_valid = ov_q;
   assign count     = count_q;
   assign all_flag  = all_q;

endmodule

// File: doc/clz_iter.md
# clz_iter

Parametrised, multi-cycle leading-zero / leading-one counter for the ALU's `clz`/`clo` path. It replaces a purely combinational priority chain with an iterative scanner that examines `CHUNK` bits per cycle from the MSB and terminates early. Operands enter and results leave through valid/ready handshakes, so the ALU stall logic can hold the pipeline around it. Width, chunk size and mode (zeros or ones) are selectable.

## Interface
Parameters:
- `WIDTH`, 32: operand width. Must be a multiple of `CHUNK` and at least 2.
- `CHUNK`, 8: bits examined per scan cycle. Must be 1 to `WIDTH`, and `WIDTH % CHUNK == 0`.
- Derived, not overridable: `NCH = WIDTH/CHUNK`, `CW = $clog2(WIDTH+1)`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: operand offered.
- `in_ready` out 1: block can accept an operand.
- `data_in` in `WIDTH`: operand.
- `mode` in 1: 0 counts leading zeros (clz), 1 counts leading ones (clo). Sampled with `data_in`.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer takes the result.
- `count` out `CW`: number of leading zeros or ones, in the range 0..`WIDTH`.
- `all_flag` out 1: high when `count == WIDTH`, meaning the operand is all zeros (clz) or all ones (clo).

## Operation
- State machine states: IDLE, SCAN, DONE.
- **IDLE**
  - `in_ready = 1`.
  - An accept is `in_valid & in_ready`. On accept:
    - `sreg <= mode ? ~data_in : data_in`
    - `count <= 0`
    - `idx <= 0`
    - go to SCAN.
  - `in_valid` without acceptance has no effect.
- **SCAN**, one chunk per cycle. Let `top = sreg[WIDTH-1 -: CHUNK]`.
  - If `top != 0`:
    - `count <= count + lz(top)`, where `lz` is the number of leading zeros within `top`, from 0 to `CHUNK-1`.
    - Go to DONE.
  - Else if `idx == NCH-1`:
    - `count <= WIDTH`.
    - Go to DONE.
  - Else:
    - `count <= count + CHUNK`
    - `sreg <= sreg << CHUNK`
    - `idx <= idx + 1`
    - Stay in SCAN.
- **DONE**
  - `out_valid = 1`.
  - `count` and `all_flag` are held stable until `out_valid & out_ready`, then go to IDLE.
  - `in_ready = 0` in DONE, so there is no accept in the same cycle as a result handoff.
- In SCAN and DONE, `in_ready = 0`. `data_in` and `mode` are ignored there.
- Arithmetic rules:
  - `count` is `CW` bits wide and never exceeds `WIDTH`.
  - `idx` is `$clog2(NCH)` bits wide, minimum 1, and never wraps within one operation.
- `mode` inversion is applied once, at accept. The scan logic only ever searches for a 1.

## Timing
- Reset values, applied at the first rising edge with `rst = 1`:
  - state = IDLE
  - `count = 0`, `all_flag = 0`, `out_valid = 0`
  - `sreg = 0`, `idx = 0`
- `in_ready` is forced to 0 while `rst = 1`.
- Reset asserted during SCAN or DONE aborts the operation. No `out_valid` is produced for the aborted operand.
- Latency: accept at edge E0. Let the first chunk containing a 1 (after inversion) have index k, counted from the MSB; for an operand with no 1, k = `NCH-1`. Then `out_valid` rises after edge E0+k+1.
  - Minimum latency is 1 cycle.
  - Maximum latency is `NCH` cycles (4 for the default parameters).
- `out_valid` stays high across any number of `out_ready = 0` cycles.
- The handoff edge returns to IDLE, so `in_ready = 1` in the following cycle.
- Back-to-back throughput with `out_ready` tied high: one result every k+3 cycles (accept, k+1 scan cycles, DONE).
- `CHUNK = WIDTH` gives a fixed 1-cycle scan. `CHUNK = 1` gives a bit-serial scan of up to `WIDTH` cycles.
- All outputs are registered except `in_ready`, which is decoded from state and `rst`.

## Test plan
- Defaults, `mode = 0`, `data_in = 0x8000_0000` → `out_valid` 1 cycle after accept, `count = 0`, `all_flag = 0`.
- Defaults, `mode = 0`, `data_in = 0x0000_0001` → `out_valid` 4 cycles after accept, `count = 31`. Then `data_in = 0` → 4 cycles, `count = 32`, `all_flag = 1`.
- Defaults, `mode = 1`:
  - `data_in = 0xFFF0_0000` → 2 cycles, `count = 12`.
  - `data_in = 0xFFFF_FFFF` → `count = 32`, `all_flag = 1`.
  - `data_in = 0x7FFF_FFFF` → `count = 0`.
- Backpressure: `data_in = 0x0001_0000` with `out_ready` low for 5 cycles → `count = 15` held stable. `in_ready = 0` throughout, and a second `in_valid` pulse is ignored. The result hands off on the first cycle `out_ready = 1`, and `in_ready = 1` on the next cycle.
- Reset mid-operation: accept `data_in = 0`, assert `rst` on the 2nd scan cycle → next cycle state is IDLE, `out_valid = 0`, `count = 0`. No spurious result after `rst` drops.
- Random sweep over `WIDTH`/`CHUNK` in {32/8, 32/1, 32/32, 16/4}: 10k random operands with biased leading runs and both modes. Each `count` must equal a reference priority-encoder model, and each latency must equal k+1.
